tdm_frame_collector: RTL and testbench
======================================

Name: tdm_frame_collector

Overview:
- Downstream consumer of the 4-channel TDM mux/decoder/latch chain.
- Each cycle it samples the latched one-hot decoder word together with the slot counter value, and routes the recovered bit into that channel's shift register.
- After FRAME_BITS complete slot rounds it publishes one parallel frame (all channels) on a valid/ready output.
- It also flags slot slips and malformed decoder words.

Parameters:
- FRAME_BITS, 8: bits collected per channel per frame; legal range 2..32.
- NCH, 4: channel count; fixed by the 2-bit slot, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- sample_en  in  1  1 = slot_in/y_in valid this cycle.
- slot_in  in  2  slot counter value {s1,s0}.
- y_in  in  4  latched decoder output; one-hot 4'b1000>>slot_in when the mux bit is 1, 4'b0000 when 0.
- frame_data  out  NCH*FRAME_BITS  channel c at [c*FRAME_BITS +: FRAME_BITS]; MSB = first bit received.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  consumer accepts when frame_valid & frame_ready.
- slip_err  out  1  sticky: slot sequence broken.
- onehot_err  out  1  sticky: y_in not in {0, expected one-hot}.
- overflow  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (reset=0 at a clk edge): frame_data=0, frame_valid=0, all sticky flags=0, shift registers cleared, round count=0, state=HUNT. Reset overrides everything, including a frame completing the same cycle.
- Cycles with sample_en=0: no state change except the output handshake.
- Bit recovery: bit = |y_in.
- onehot_err sets when sample_en=1 and y_in is neither 0 nor 4'b1000>>slot_in. The bit is still taken as |y_in.
- FSM, 2 states.
  - HUNT: samples ignored until sample_en=1 and slot_in=0. That sample is stored as round 0 / channel 0; go to COLLECT with exp_slot=1.
  - COLLECT, slot_in==exp_slot: shift bit into channel slot_in's register, exp_slot wraps 3->0.
    - slot 3 increments the round count.
    - When the round count reaches FRAME_BITS-1 on a slot-3 sample, the frame is complete: round count returns to 0, stay in COLLECT.
  - COLLECT, slot_in!=exp_slot: set slip_err and discard the partial frame (registers and round count cleared).
    - If slot_in==0, that sample starts a new frame (stay COLLECT, exp_slot=1).
    - Otherwise go to HUNT.
- Frame publish latency: frame_valid rises on the clk edge that registers the final slot-3 sample. Visible the cycle after that sample is presented; no further delay.
- Handshake:
  - frame_valid and frame_data stay stable until frame_valid & frame_ready; frame_valid then drops next cycle.
  - Completion with frame_valid=0, or in the same cycle as a handshake: load the new frame, frame_valid=1 (back-to-back, no bubble).
  - Completion with frame_valid=1 & frame_ready=0: new frame dropped, overflow set, old frame retained.
- Sticky flags clear only on reset.
- Arithmetic: round count is $clog2(FRAME_BITS) bits; exp_slot is 2 bits with natural wrap.

Decomposition:
- Package tdm_pkg:
  - NCH=4 and SLOT_W=2.
  - FSM state enum {HUNT, COLLECT}.
  - Function slot_onehot(slot) returning 4'b1000>>slot; shared with the decoder.
- One sub-module, tdm_chan_shreg: a FRAME_BITS shift register with load-enable and synchronous clear, instantiated NCH times.
- FSM, round counter, output holding register and flags stay in the top module.

Test Plan (FRAME_BITS=8):
1. Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0. Release, then hold slot_in=2 for 5 samples -> stays HUNT, no frame_valid, no errors (slip is not checked in HUNT).
2. Clean frame: 32 samples, slots 0,1,2,3 repeating, channel bits ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x01 MSB first, frame_ready=1.
   - frame_valid=1 exactly one cycle after the 32nd sample.
   - frame_data=32'h01FF3CA5.
   - No flags set.
3. Backpressure: frame_ready=0 across two complete frames (second frame ch0=0x11) -> first frame held unchanged, overflow=1. Then frame_ready=1 for one cycle -> frame_valid drops.
4. Back-to-back: frame_ready=1 on the same edge that frame 2 completes -> frame_valid stays 1, frame_data updates to frame 2, overflow=0.
5. Slot slip:
   - Sequence 0,1,3 mid-frame -> slip_err=1, partial data lost, state HUNT.
   - Then a clean 32-sample frame starting at slot 0 -> correct frame.
   - Variant 0,1,0 -> restart immediately, no HUNT.
6. Bad decode and reset:
   - y_in=4'b0110 at slot 1 -> onehot_err=1, bit recorded as 1.
   - reset=0 at sample 20 of a frame -> all cleared; the next frame decodes cleanly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and slot decode helper for the TDM
// mux/decoder/latch chain and its frame collector.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Decoder word expected for a given slot when the mux bit is 1.
  function automatic logic [NCH-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    return 4'b1000 >> slot;
  endfunction

endpackage

// File: rtl/tdm_chan_shreg.sv
// Per-channel serial-to-parallel shift register; first bit received ends up in the MSB.
module tdm_chan_shreg #(
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      // Clearing and loading together starts a fresh frame with din as its first bit.
      q <= '0;
      if (en) q[0] <= din;
    end else if (en) begin
      q <= {q[FRAME_BITS-2:0], din};
    end
  end

endmodule

// File: rtl/tdm_frame_collector.sv
// Collects FRAME_BITS slot rounds of the 4-channel TDM stream into one parallel
// frame, published on a valid/ready port, with sticky slip/decode/overflow flags.
module tdm_frame_collector
  import tdm_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [SLOT_W-1:0]         slot_in,
  input  logic [NCH-1:0]            y_in,
  output logic [NCH*FRAME_BITS-1:0] frame_data,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      slip_err,
  output logic                      onehot_err,
  output logic                      overflow
);

  localparam int RW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [RW-1:0]     LAST_RND  = RW'(FRAME_BITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);

  state_t                  state;
  logic [SLOT_W-1:0]       exp_slot;
  logic [RW-1:0]           rnd;
  logic                    bit_in;
  logic                    start;
  logic                    adv;
  logic                    slip;
  logic                    clr_all;
  logic                    complete;
  logic                    bad_word;
  logic [NCH-1:0]          sh_en;
  logic [FRAME_BITS-1:0]   q [NCH];
  logic [NCH*FRAME_BITS-1:0] frame_next;

  assign bit_in   = |y_in;
  assign bad_word = sample_en && (y_in != '0) && (y_in != slot_onehot(slot_in));

  always_comb begin
    start = 1'b0;
    adv   = 1'b0;
    slip  = 1'b0;
    if (sample_en) begin
      if (state == HUNT) begin
        start = (slot_in == '0);
      end else if (slot_in == exp_slot) begin
        adv = 1'b1;
      end else begin
        slip  = 1'b1;
        start = (slot_in == '0);
      end
    end
    clr_all  = start | slip;
    complete = adv && (slot_in == LAST_SLOT) && (rnd == LAST_RND);
    for (int unsigned c = 0; c < NCH; c++) begin
      sh_en[c] = (adv && (slot_in == SLOT_W'(c))) || (start && (c == 0));
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tdm_chan_shreg #(.FRAME_BITS(FRAME_BITS)) u_shreg (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_all),
      .en    (sh_en[c]),
      .din   (bit_in),
      .q     (q[c])
    );
    // The last channel's final bit arrives with the completing sample, so fold it in here.
    if (c == NCH - 1) begin : g_last
      assign frame_next[c*FRAME_BITS +: FRAME_BITS] = {q[c][FRAME_BITS-2:0], bit_in};
    end else begin : g_mid
      assign frame_next[c*FRAME_BITS +: FRAME_BITS] = q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HUNT;
      exp_slot    <= '0;
      rnd         <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      slip_err    <= 1'b0;
      onehot_err  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (bad_word) onehot_err <= 1'b1;
      if (slip)     slip_err   <= 1'b1;

      if (start) begin
        state    <= COLLECT;
        exp_slot <= SLOT_W'(1);
        rnd      <= '0;
      end else if (slip) begin
        state <= HUNT;
        rnd   <= '0;
      end else if (adv) begin
        exp_slot <= exp_slot + 1'b1;
        if (slot_in == LAST_SLOT) rnd <= complete ? '0 : rnd + 1'b1;
      end

      if (complete) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= frame_next;
          frame_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_frame_collector.sv
// Self-checking bench for tdm_frame_collector (FRAME_BITS=8): directed scenarios
// plus randomized traffic, compared against a queue-based reference model.
module tb_tdm_frame_collector;

  localparam int FB = 8;
  localparam int NS = 4 * FB;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic [1:0]    slot_in;
  logic [3:0]    y_in;
  logic [NS-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          slip_err;
  logic          onehot_err;
  logic          overflow;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic          m_valid, m_slip, m_onehot, m_ovf;
  logic [NS-1:0] m_data;
  bit            m_in_frame;
  bit            m_cur[$];

  tdm_frame_collector #(.FRAME_BITS(FB)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .slot_in     (slot_in),
    .y_in        (y_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .slip_err    (slip_err),
    .onehot_err  (onehot_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Frame bookkeeping by sample index: sample i is slot i%4 of round i/4.
  task automatic model_tick(input logic rst, input logic en, input logic [1:0] s,
                            input logic [3:0] y, input logic rdy);
    bit            done;
    bit            b;
    logic [3:0]    oh;
    logic [NS-1:0] nf;
    done = 0;
    nf   = '0;
    if (!rst) begin
      m_valid = 0; m_slip = 0; m_onehot = 0; m_ovf = 0; m_data = '0;
      m_in_frame = 0;
      m_cur.delete();
      return;
    end
    if (en) begin
      b  = (y != 4'd0);
      oh = 4'b1000 >> s;
      if (y != 4'd0 && y != oh) m_onehot = 1;
      if (!m_in_frame) begin
        if (s == 2'd0) begin
          m_in_frame = 1;
          m_cur.delete();
          m_cur.push_back(b);
        end
      end else if (int'(s) == m_cur.size() % 4) begin
        m_cur.push_back(b);
        if (m_cur.size() == NS) begin
          done = 1;
          for (int i = 0; i < NS; i++) nf[(i % 4) * FB + (FB - 1) - i / 4] = m_cur[i];
          m_cur.delete();
        end
      end else begin
        m_slip = 1;
        m_cur.delete();
        if (s == 2'd0) m_cur.push_back(b);
        else m_in_frame = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = nf;
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [1:0] s,
                      input logic [3:0] y, input logic rdy);
    reset       = rst;
    sample_en   = en;
    slot_in     = s;
    y_in        = y;
    frame_ready = rdy;
    model_tick(rst, en, s, y, rdy);
    @(posedge clk);
    #1;
  endtask

  // Sends samples first..last-1 of frame f; bad_at forces y_in=4'b0110 at that index.
  task automatic send_frame(input logic [NS-1:0] f, input int first, input int last,
                            input logic rdy, input logic rdy_last, input int bad_at);
    int         c, k;
    logic [3:0] y;
    for (int i = first; i < last; i++) begin
      c = i % 4;
      k = i / 4;
      y = f[c * FB + (FB - 1) - k] ? (4'b1000 >> c) : 4'd0;
      if (i == bad_at) y = 4'b0110;
      step(1'b1, 1'b1, 2'(c), y, (i == NS - 1) ? rdy_last : rdy);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    logic [3:0] y;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
    checks++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", frame_valid); else passes++;
    checks++; if (frame_data !== '0) $display("FAIL reset_data got %h exp 0", frame_data); else passes++;
    checks++; if (slip_err !== 1'b0) $display("FAIL reset_slip got %b exp 0", slip_err); else passes++;
    checks++; if (onehot_err !== 1'b0) $display("FAIL reset_onehot got %b exp 0", onehot_err); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else passes++;
    for (int i = 0; i < 5; i++) begin
      y = $urandom_range(0, 1) ? 4'b0010 : 4'd0;
      step(1'b1, 1'b1, 2'd2, y, 1'b1);
    end
    checks++; if (frame_valid !== 1'b0) $display("FAIL hunt_valid got %b exp 0", frame_valid); else passes++;
    checks++; if (slip_err !== 1'b0) $display("FAIL hunt_slip got %b exp 0", slip_err); else passes++;
    checks++; if (onehot_err !== 1'b0) $display("FAIL hunt_onehot got %b exp 0", onehot_err); else passes++;
  endtask

  task automatic test_clean_frame();
    send_frame(32'h01FF3CA5, 0, NS - 1, 1'b1, 1'b1, -1);
    checks++; if (frame_valid !== 1'b0) $display("FAIL clean_early_valid got %b exp 0", frame_valid); else passes++;
    send_frame(32'h01FF3CA5, NS - 1, NS, 1'b1, 1'b1, -1);
    checks++; if (frame_valid !== 1'b1) $display("FAIL clean_valid got %b exp 1", frame_valid); else passes++;
    checks++; if (frame_data !== 32'h01FF3CA5) $display("FAIL clean_data got %h exp 01ff3ca5", frame_data); else passes++;
    checks++; if ({slip_err, onehot_err, overflow} !== 3'b000)
      $display("FAIL clean_flags got %b exp 000", {slip_err, onehot_err, overflow}); else passes++;
    step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
    checks++; if (frame_valid !== 1'b0) $display("FAIL clean_consume got %b exp 0", frame_valid); else passes++;
  endtask

  task automatic test_backpressure();
    send_frame(32'h01FF3CA5, 0, NS, 1'b0, 1'b0, -1);
    checks++; if (frame_valid !== 1'b1) $display("FAIL bp_first_valid got %b exp 1", frame_valid); else passes++;
    send_frame(32'h01FF3C11, 0, NS, 1'b0, 1'b0, -1);
    checks++; if (frame_data !== 32'h01FF3CA5) $display("FAIL bp_hold_data got %h exp 01ff3ca5", frame_data); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow got %b exp 1", overflow); else passes++;
    checks++; if (frame_valid !== 1'b1) $display("FAIL bp_hold_valid got %b exp 1", frame_valid); else passes++;
    step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
    checks++; if (frame_valid !== 1'b0) $display("FAIL bp_drop_valid got %b exp 0", frame_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] f1, f2;
    f1 = NS'($urandom);
    f2 = NS'($urandom);
    do_reset();
    send_frame(f1, 0, NS, 1'b0, 1'b0, -1);
    checks++; if (frame_data !== f1) $display("FAIL b2b_f1_data got %h exp %h", frame_data, f1); else passes++;
    send_frame(f2, 0, NS, 1'b0, 1'b1, -1);
    checks++; if (frame_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", frame_valid); else passes++;
    checks++; if (frame_data !== f2) $display("FAIL b2b_f2_data got %h exp %h", frame_data, f2); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b exp 0", overflow); else passes++;
  endtask

  task automatic test_slot_slip();
    logic [NS-1:0] f1, f2, f3;
    f1 = NS'($urandom);
    f2 = NS'($urandom);
    f3 = NS'($urandom);
    do_reset();
    send_frame(f1, 0, 2, 1'b1, 1'b1, -1);
    step(1'b1, 1'b1, 2'd3, 4'b0001, 1'b1);
    checks++; if (slip_err !== 1'b1) $display("FAIL slip_flag got %b exp 1", slip_err); else passes++;
    step(1'b1, 1'b1, 2'd1, 4'b0100, 1'b1);
    step(1'b1, 1'b1, 2'd2, 4'b0010, 1'b1);
    send_frame(f2, 0, NS, 1'b1, 1'b1, -1);
    checks++; if (frame_valid !== 1'b1) $display("FAIL slip_resync_valid got %b exp 1", frame_valid); else passes++;
    checks++; if (frame_data !== f2) $display("FAIL slip_resync_data got %h exp %h", frame_data, f2); else passes++;
    send_frame(f1, 0, 2, 1'b1, 1'b1, -1);
    send_frame(f3, 0, NS, 1'b1, 1'b1, -1);
    checks++; if (frame_valid !== 1'b1) $display("FAIL slip_restart_valid got %b exp 1", frame_valid); else passes++;
    checks++; if (frame_data !== f3) $display("FAIL slip_restart_data got %h exp %h", frame_data, f3); else passes++;
  endtask

  task automatic test_bad_decode();
    logic [NS-1:0] f, g, h;
    f = 32'h5A5A0F0F;
    g = NS'($urandom);
    h = NS'($urandom);
    do_reset();
    send_frame(f, 0, 2, 1'b1, 1'b1, 1);
    checks++; if (onehot_err !== 1'b1) $display("FAIL bad_onehot got %b exp 1", onehot_err); else passes++;
    send_frame(f, 2, NS, 1'b1, 1'b1, -1);
    checks++; if (frame_data !== 32'h5A5A8F0F) $display("FAIL bad_bit_data got %h exp 5a5a8f0f", frame_data); else passes++;
    checks++; if (slip_err !== 1'b0) $display("FAIL bad_slip got %b exp 0", slip_err); else passes++;
    send_frame(g, 0, 19, 1'b1, 1'b1, -1);
    step(1'b0, 1'b1, 2'd3, 4'b0001, 1'b1);
    checks++; if ({frame_valid, slip_err, onehot_err, overflow} !== 4'b0000)
      $display("FAIL midreset_flags got %b exp 0000", {frame_valid, slip_err, onehot_err, overflow}); else passes++;
    checks++; if (frame_data !== '0) $display("FAIL midreset_data got %h exp 0", frame_data); else passes++;
    send_frame(h, 0, NS, 1'b1, 1'b1, -1);
    checks++; if (frame_data !== h) $display("FAIL postreset_data got %h exp %h", frame_data, h); else passes++;
    checks++; if ({frame_valid, onehot_err} !== 2'b10)
      $display("FAIL postreset_status got %b exp 10", {frame_valid, onehot_err}); else passes++;
  endtask

  task automatic test_random();
    logic [1:0] s, nxt;
    logic [3:0] y;
    logic       en;
    nxt = 2'd0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      s  = nxt;
      if ($urandom_range(0, 59) == 0) s = 2'($urandom);
      y  = $urandom_range(0, 1) ? (4'b1000 >> s) : 4'd0;
      if ($urandom_range(0, 199) == 0) y = 4'($urandom_range(1, 15));
      if (en) nxt = s + 2'd1;
      step(1'b1, en, s, y, ($urandom_range(0, 3) != 0));
      checks++; if (frame_valid !== m_valid) $display("FAIL rnd_valid cyc %0d got %b exp %b", i, frame_valid, m_valid); else passes++;
      checks++; if (frame_data !== m_data) $display("FAIL rnd_data cyc %0d got %h exp %h", i, frame_data, m_data); else passes++;
      checks++; if (slip_err !== m_slip) $display("FAIL rnd_slip cyc %0d got %b exp %b", i, slip_err, m_slip); else passes++;
      checks++; if (onehot_err !== m_onehot) $display("FAIL rnd_onehot cyc %0d got %b exp %b", i, onehot_err, m_onehot); else passes++;
      checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, overflow, m_ovf); else passes++;
    end
  endtask

  initial begin
    reset       = 1'b0;
    sample_en   = 1'b0;
    slot_in     = 2'd0;
    y_in        = 4'd0;
    frame_ready = 1'b0;
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_back_to_back();
    test_slot_slip();
    test_bad_decode();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
